// File: rtl/jvm_bytecode_pkg.sv
// ---------------------------------------------------------------------------
// jvm_bytecode_pkg
//
// Shared definitions for the bytecode front end:
//   - JVM opcode constants used by the length decoder and its users
//   - 2-bit operand-length class encoding
//   - assembler FSM state encoding
//   - helper mapping a length class to an operand byte count
// ---------------------------------------------------------------------------
package jvm_bytecode_pkg;

    // Constants and the simple zero-operand opcodes
    localparam logic [7:0] OP_NOP             = 8'h00;
    localparam logic [7:0] OP_ICONST_0        = 8'h03;
    localparam logic [7:0] OP_RETURN          = 8'hB1;

    // Push / constant-pool loads
    localparam logic [7:0] OP_BIPUSH          = 8'h10;
    localparam logic [7:0] OP_SIPUSH          = 8'h11;
    localparam logic [7:0] OP_LDC             = 8'h12;
    localparam logic [7:0] OP_LDC_W           = 8'h13;
    localparam logic [7:0] OP_LDC2_W          = 8'h14;

    // Local-variable loads/stores with an explicit index byte
    localparam logic [7:0] OP_ILOAD           = 8'h15;
    localparam logic [7:0] OP_ALOAD           = 8'h19;
    localparam logic [7:0] OP_ISTORE          = 8'h36;
    localparam logic [7:0] OP_ASTORE          = 8'h3A;
    localparam logic [7:0] OP_IINC            = 8'h84;

    // Conditional and unconditional branches with a 16-bit offset
    localparam logic [7:0] OP_IFEQ            = 8'h99;
    localparam logic [7:0] OP_GOTO            = 8'hA7;
    localparam logic [7:0] OP_JSR             = 8'hA8;
    localparam logic [7:0] OP_RET             = 8'hA9;
    localparam logic [7:0] OP_TABLESWITCH     = 8'hAA;
    localparam logic [7:0] OP_LOOKUPSWITCH    = 8'hAB;

    // Field access and invocation
    localparam logic [7:0] OP_GETSTATIC       = 8'hB2;
    localparam logic [7:0] OP_INVOKESTATIC    = 8'hB8;
    localparam logic [7:0] OP_INVOKEINTERFACE = 8'hB9;
    localparam logic [7:0] OP_INVOKEDYNAMIC   = 8'hBA;

    // Object creation and type checks
    localparam logic [7:0] OP_NEW             = 8'hBB;
    localparam logic [7:0] OP_NEWARRAY        = 8'hBC;
    localparam logic [7:0] OP_ANEWARRAY       = 8'hBD;
    localparam logic [7:0] OP_CHECKCAST       = 8'hC0;
    localparam logic [7:0] OP_INSTANCEOF      = 8'hC1;

    // Extended forms
    localparam logic [7:0] OP_WIDE            = 8'hC4;
    localparam logic [7:0] OP_MULTIANEWARRAY  = 8'hC5;
    localparam logic [7:0] OP_IFNULL          = 8'hC6;
    localparam logic [7:0] OP_IFNONNULL       = 8'hC7;
    localparam logic [7:0] OP_GOTO_W          = 8'hC8;
    localparam logic [7:0] OP_JSR_W           = 8'hC9;

    // Operand length class of an opcode. LEN_UNSUP covers variable-length
    // (switches, wide) and 3/4-operand-byte forms the assembler cannot build.
    typedef enum logic [1:0] {
        LEN0      = 2'd0,
        LEN1      = 2'd1,
        LEN2      = 2'd2,
        LEN_UNSUP = 2'd3
    } len_class_t;

    // Assembler states
    typedef enum logic [2:0] {
        S_OPCODE = 3'd0,
        S_OP_HI  = 3'd1,
        S_OP_LO1 = 3'd2,
        S_OP_LO2 = 3'd3,
        S_EMIT   = 3'd4,
        S_HALT   = 3'd5
    } asm_state_t;

    // Number of operand bytes reported for a length class; unsupported
    // opcodes report none because no operands are collected for them.
    function automatic logic [1:0] len_to_count(input len_class_t len);
        case (len)
            LEN1:    return 2'd1;
            LEN2:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage : jvm_bytecode_pkg

// File: rtl/bytecode_length_decode.sv
// ---------------------------------------------------------------------------
// bytecode_length_decode
//
// Purely combinational opcode -> operand length class lookup. Shared between
// the fetch assembler and the JIT branch-target scanner.
//
// Ports:
//   i_opcode     in   8  opcode byte
//   o_len_class  out  2  LEN0 / LEN1 / LEN2 / LEN_UNSUP
// ---------------------------------------------------------------------------
module bytecode_length_decode
    import jvm_bytecode_pkg::*;
(
    input  logic [7:0] i_opcode,
    output len_class_t o_len_class
);

    len_class_t w_len_class;

    always_comb begin
        // NOTE: a default assignment ahead of the case guarantees every path
        // drives the output, so no latch can be inferred.
        w_len_class = LEN0;
        case (i_opcode) inside
            OP_TABLESWITCH, OP_LOOKUPSWITCH,
            OP_INVOKEINTERFACE, OP_INVOKEDYNAMIC,
            OP_WIDE, OP_MULTIANEWARRAY,
            OP_GOTO_W, OP_JSR_W:
                w_len_class = LEN_UNSUP;

            OP_SIPUSH, OP_LDC_W, OP_LDC2_W, OP_IINC,
            [OP_IFEQ:OP_JSR],
            [OP_GETSTATIC:OP_INVOKESTATIC],
            OP_NEW, OP_ANEWARRAY, OP_CHECKCAST, OP_INSTANCEOF,
            OP_IFNULL, OP_IFNONNULL:
                w_len_class = LEN2;

            OP_BIPUSH, OP_LDC,
            [OP_ILOAD:OP_ALOAD],
            [OP_ISTORE:OP_ASTORE],
            OP_RET, OP_NEWARRAY:
                w_len_class = LEN1;

            default:
                w_len_class = LEN0;
        endcase
    end

    assign o_len_class = w_len_class;

endmodule : bytecode_length_decode

// File: rtl/bytecode_fetch_assembler.sv
// ---------------------------------------------------------------------------
// bytecode_fetch_assembler
//
// Consumes the raw bytecode byte stream from the fetcher, decodes each
// opcode's operand length, gathers 0..2 big-endian operand bytes and
// presents one assembled instruction to the JIT stage over valid/ready.
// byte_take drives the fetcher's start input, so stalling here throttles
// fetch.
//
// Ports:
//   clk            in   1   system clock
//   reset          in   1   synchronous active-low reset
//   byte_in        in   8   bytecode byte from the fetcher
//   byte_valid     in   1   byte_in valid
//   byte_take      out  1   consume request; byte accepted on valid & take
//   flush          in   1   synchronous redirect
//   flush_pc       in   AW  byte PC of the first byte after a flush
//   instr_valid    out  1   assembled instruction available
//   instr_ready    in   1   consumer accepts the instruction
//   opcode         out  8   opcode byte
//   operand        out  16  operand bytes, big-endian, 1 byte zero-extended
//   operand_count  out  2   number of operand bytes (0..2)
//   instr_pc       out  AW  byte PC of the opcode
//   unsupported    out  1   opcode length class not handled; block halts
// ---------------------------------------------------------------------------
module bytecode_fetch_assembler
    import jvm_bytecode_pkg::*;
#(
    parameter int unsigned                ADDRESS_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0]   PC_RESET_VALUE = '0
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_take,
    input  logic                     flush,
    input  logic [ADDRESS_WIDTH-1:0] flush_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [7:0]               opcode,
    output logic [15:0]              operand,
    output logic [1:0]               operand_count,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     unsupported
);

    asm_state_t               r_state;
    logic [ADDRESS_WIDTH-1:0] r_byte_pc;
    logic                     r_instr_valid;
    logic [7:0]               r_opcode;
    logic [15:0]              r_operand;
    logic [1:0]               r_operand_count;
    logic [ADDRESS_WIDTH-1:0] r_instr_pc;
    logic                     r_unsupported;

    len_class_t               w_len_class;
    logic                     w_fetching;
    logic                     w_take;
    logic [ADDRESS_WIDTH-1:0] w_pc_next;

    bytecode_length_decode u_len_decode (
        .i_opcode    (byte_in),
        .o_len_class (w_len_class)
    );

    // Only the byte-collecting states ask for data. The request is masked
    // during reset and flush so the fetcher never advances past a byte this
    // block is about to discard.
    assign w_fetching = (r_state == S_OPCODE) || (r_state == S_OP_HI) ||
                        (r_state == S_OP_LO1) || (r_state == S_OP_LO2);
    assign w_take     = reset && !flush && byte_valid && w_fetching;
    assign w_pc_next  = r_byte_pc + ADDRESS_WIDTH'(1);

    always_ff @(posedge clk) begin
        // NOTE: every state register uses non-blocking assignment so all
        // updates in this block see the pre-edge values, like real flops.
        if (!reset) begin
            r_state         <= S_OPCODE;
            r_byte_pc       <= PC_RESET_VALUE;
            r_instr_valid   <= 1'b0;
            r_unsupported   <= 1'b0;
            r_opcode        <= 8'h00;
            r_operand       <= 16'h0000;
            r_operand_count <= 2'd0;
            r_instr_pc      <= PC_RESET_VALUE;
        end else if (flush) begin
            r_state       <= S_OPCODE;
            r_byte_pc     <= flush_pc;
            r_instr_valid <= 1'b0;
            r_unsupported <= 1'b0;
        end else begin
            case (r_state)
                S_OPCODE: begin
                    if (w_take) begin
                        r_opcode        <= byte_in;
                        r_instr_pc      <= r_byte_pc;
                        r_operand       <= 16'h0000;
                        r_operand_count <= len_to_count(w_len_class);
                        r_unsupported   <= (w_len_class == LEN_UNSUP);
                        r_byte_pc       <= w_pc_next;
                        case (w_len_class)
                            LEN1: r_state <= S_OP_LO1;
                            LEN2: r_state <= S_OP_HI;
                            default: begin
                                // No operands to gather (or none we can
                                // gather): present the opcode next cycle.
                                r_state       <= S_EMIT;
                                r_instr_valid <= 1'b1;
                            end
                        endcase
                    end
                end

                S_OP_HI: begin
                    if (w_take) begin
                        r_operand[15:8] <= byte_in;
                        r_byte_pc       <= w_pc_next;
                        r_state         <= S_OP_LO2;
                    end
                end

                S_OP_LO1, S_OP_LO2: begin
                    if (w_take) begin
                        r_operand[7:0] <= byte_in;
                        r_byte_pc      <= w_pc_next;
                        r_state        <= S_EMIT;
                        r_instr_valid  <= 1'b1;
                    end
                end

                S_EMIT: begin
                    // Instruction fields are untouched here, so they stay
                    // stable for as long as the consumer stalls.
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= r_unsupported ? S_HALT : S_OPCODE;
                    end
                end

                S_HALT: begin
                    // Byte stream alignment is lost after an unsupported
                    // opcode; wait for a redirect.
                    r_state <= S_HALT;
                end

                default: begin
                    r_state       <= S_OPCODE;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign byte_take     = w_take;
    assign instr_valid   = r_instr_valid;
    assign opcode        = r_opcode;
    assign operand       = r_operand;
    assign operand_count = r_operand_count;
    assign instr_pc      = r_instr_pc;
    assign unsupported   = r_unsupported;

endmodule : bytecode_fetch_assembler

// File: tb/tb_bytecode_fetch_assembler.sv
// ---------------------------------------------------------------------------
// tb_bytecode_fetch_assembler
//
// Self-checking bench: directed corner sequences, a table of instruction
// vectors, and a randomized byte stream compared against a reference model
// that parses the stream using the opcode length table.
// ---------------------------------------------------------------------------
module tb_bytecode_fetch_assembler;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_take;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [7:0]    opcode;
    logic [15:0]   operand;
    logic [1:0]    operand_count;
    logic [AW-1:0] instr_pc;
    logic          unsupported;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bytecode_fetch_assembler #(
        .ADDRESS_WIDTH  (AW),
        .PC_RESET_VALUE (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_take     (byte_take),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .opcode        (opcode),
        .operand       (operand),
        .operand_count (operand_count),
        .instr_pc      (instr_pc),
        .unsupported   (unsupported)
    );

    // ---------------------------------------------------------------- model
    // Operand byte count of an opcode from the JVM length table; -1 marks
    // an opcode the assembler does not handle.
    function automatic int ref_len(input logic [7:0] op);
        if (op inside {8'hAA, 8'hAB, 8'hB9, 8'hBA, 8'hC4, 8'hC5, 8'hC8, 8'hC9})
            return -1;
        if (op inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
                       8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7})
            return 2;
        if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC})
            return 1;
        return 0;
    endfunction

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] opd;
        logic [1:0]  cnt;
        logic [7:0]  pc;
    } instr_t;

    typedef struct {
        logic [23:0] bytes;   // stream bytes, first byte in [23:16]
        int          n;       // number of bytes in the instruction
        logic [15:0] opd;
        logic [1:0]  cnt;
        logic        uns;
    } vec_t;

    // ---------------------------------------------------------------- tasks
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        flush       = 1'b0;
        byte_valid  = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic do_flush(input logic [7:0] pc);
        @(negedge clk);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    // Present one byte and hold it until the DUT takes it.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        #1;
        while (byte_take !== 1'b1 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (byte_take !== 1'b1)
            check($sformatf("take_timeout_%02h", b), 32'(byte_take), 32'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int waited = 0;
        while (instr_valid !== 1'b1 && waited < 64) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (instr_valid !== 1'b1)
            check({name, "_valid_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    // Wait for an instruction, stall the consumer for 'hold' cycles, compare
    // every field, then complete the handshake and confirm a single pulse.
    task automatic expect_instr(input string name, input logic [7:0] op,
                                input logic [15:0] opd, input logic [1:0] cnt,
                                input logic [7:0] pc, input logic uns,
                                input int hold);
        wait_valid(name);
        repeat (hold) begin
            @(negedge clk);
            #1;
            check({name, "_held"}, 32'(instr_valid), 32'd1);
        end
        check({name, "_opcode"},  32'(opcode),        32'(op));
        check({name, "_operand"}, 32'(operand),       32'(opd));
        check({name, "_count"},   32'(operand_count), 32'(cnt));
        check({name, "_pc"},      32'(instr_pc),      32'(pc));
        check({name, "_unsup"},   32'(unsupported),   32'(uns));
        @(negedge clk);
        instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        check({name, "_pulse"}, 32'(instr_valid), 32'd0);
    endtask

    // ---------------------------------------------------------------- test
    vec_t          vecs[14];
    instr_t        exp_q[$];
    logic [7:0]    byte_q[$];

    initial begin : main
        logic [7:0]  tpc;
        logic [7:0]  op, a, b;
        logic [15:0] opd;
        int          n;

        vecs = '{
            '{24'h030000, 1, 16'h0000, 2'd0, 1'b0},
            '{24'h10FE00, 2, 16'h00FE, 2'd1, 1'b0},
            '{24'h111234, 3, 16'h1234, 2'd2, 1'b0},
            '{24'h840105, 3, 16'h0105, 2'd2, 1'b0},
            '{24'h150700, 2, 16'h0007, 2'd1, 1'b0},
            '{24'hA90300, 2, 16'h0003, 2'd1, 1'b0},
            '{24'hBC0A00, 2, 16'h000A, 2'd1, 1'b0},
            '{24'hC70010, 3, 16'h0010, 2'd2, 1'b0},
            '{24'h99FFF0, 3, 16'hFFF0, 2'd2, 1'b0},
            '{24'hB80002, 3, 16'h0002, 2'd2, 1'b0},
            '{24'h600000, 1, 16'h0000, 2'd0, 1'b0},
            '{24'h3A0400, 2, 16'h0004, 2'd1, 1'b0},
            '{24'hA88000, 3, 16'h8000, 2'd2, 1'b0},
            '{24'hC80000, 1, 16'h0000, 2'd0, 1'b1}
        };

        reset       = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        flush       = 1'b0;
        flush_pc    = 8'h00;
        instr_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid",   32'(instr_valid),   32'd0);
        check("rst_opcode",  32'(opcode),        32'h00);
        check("rst_operand", 32'(operand),       32'h0000);
        check("rst_count",   32'(operand_count), 32'd0);
        check("rst_pc",      32'(instr_pc),      32'h00);
        check("rst_unsup",   32'(unsupported),   32'd0);
        check("rst_take",    32'(byte_take),     32'd0);

        // iconst_0: valid the cycle after the only byte is taken
        send_byte(8'h03);
        check("iconst_latency", 32'(instr_valid), 32'd1);
        expect_instr("iconst", 8'h03, 16'h0000, 2'd0, 8'h00, 1'b0, 0);

        // bipush -2, then the next opcode lands at PC 2
        do_reset();
        send_byte(8'h10);
        check("bipush_mid", 32'(instr_valid), 32'd0);
        send_byte(8'hFE);
        check("bipush_latency", 32'(instr_valid), 32'd1);
        expect_instr("bipush", 8'h10, 16'h00FE, 2'd1, 8'h00, 1'b0, 0);
        send_byte(8'h00);
        expect_instr("nop_after", 8'h00, 16'h0000, 2'd0, 8'h02, 1'b0, 0);

        // iinc with idle gaps between bytes, then a stalled consumer
        send_byte(8'h84);
        repeat (3) begin
            @(negedge clk); #1;
            check("iinc_gap1_valid", 32'(instr_valid), 32'd0);
        end
        send_byte(8'h01);
        repeat (3) begin
            @(negedge clk); #1;
            check("iinc_gap2_valid", 32'(instr_valid), 32'd0);
        end
        send_byte(8'h05);
        repeat (4) begin
            @(negedge clk);
            byte_in    = 8'h77;
            byte_valid = 1'b1;
            #1;
            check("iinc_stall_take",    32'(byte_take),   32'd0);
            check("iinc_stall_valid",   32'(instr_valid), 32'd1);
            check("iinc_stall_operand", 32'(operand),     32'h0105);
        end
        byte_valid = 1'b0;
        expect_instr("iinc", 8'h84, 16'h0105, 2'd2, 8'h03, 1'b0, 0);

        // tableswitch halts the block until a flush
        send_byte(8'hAA);
        expect_instr("tswitch", 8'hAA, 16'h0000, 2'd0, 8'h06, 1'b1, 0);
        repeat (4) begin
            @(negedge clk);
            byte_in    = 8'hB1;
            byte_valid = 1'b1;
            #1;
            check("halt_take",  32'(byte_take),   32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
        end
        @(negedge clk);
        flush    = 1'b1;
        flush_pc = 8'h40;
        #1;
        check("flush_take", 32'(byte_take), 32'd0);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        byte_valid = 1'b0;
        check("flush_unsup", 32'(unsupported), 32'd0);
        send_byte(8'hB1);
        expect_instr("return", 8'hB1, 16'h0000, 2'd0, 8'h40, 1'b0, 0);

        // Reset in the middle of a sipush discards its partial operand
        send_byte(8'h11);
        send_byte(8'h12);
        do_reset();
        check("midrst_valid", 32'(instr_valid), 32'd0);
        send_byte(8'h00);
        expect_instr("midrst_nop", 8'h00, 16'h0000, 2'd0, 8'h00, 1'b0, 0);

        // Byte PC wraps from 0xFF
        do_flush(8'hFF);
        send_byte(8'h11);
        send_byte(8'hAA);
        send_byte(8'hBB);
        expect_instr("wrap_sipush", 8'h11, 16'hAABB, 2'd2, 8'hFF, 1'b0, 1);
        send_byte(8'h00);
        expect_instr("wrap_nop", 8'h00, 16'h0000, 2'd0, 8'h02, 1'b0, 0);

        // Table-driven vectors from PC 0
        do_reset();
        tpc = 8'h00;
        for (int i = 0; i < 14; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                send_byte(vecs[i].bytes[23 - 8*j -: 8]);
            expect_instr($sformatf("vec%0d", i), vecs[i].bytes[23:16],
                         vecs[i].opd, vecs[i].cnt, tpc, vecs[i].uns, i % 3);
            tpc = tpc + 8'(vecs[i].n);
        end

        // Randomized stream against the parsing model
        do_reset();
        tpc = 8'h00;
        for (int i = 0; i < 40; i++) begin
            do op = 8'($urandom_range(0, 255)); while (ref_len(op) < 0);
            n = ref_len(op);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            byte_q.push_back(op);
            if (n >= 1) byte_q.push_back(a);
            if (n == 2) byte_q.push_back(b);
            opd = (n == 2) ? {a, b} : (n == 1) ? {8'h00, a} : 16'h0000;
            exp_q.push_back('{op, opd, 2'(n), tpc});
            tpc = tpc + 8'(1 + n);
        end
        fork
            begin
                foreach (byte_q[k]) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send_byte(byte_q[k]);
                end
            end
            begin
                foreach (exp_q[k])
                    expect_instr($sformatf("rnd%0d", k), exp_q[k].op,
                                 exp_q[k].opd, exp_q[k].cnt, exp_q[k].pc,
                                 1'b0, int'($urandom_range(0, 3)));
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far",
                 n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bytecode_fetch_assembler
